addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter_pkg.sv | 16 +
 rtl/addsub_arbiter_rr_arbiter.sv | 46 ++++
 rtl/addsub_arbiter.sv | 111 +++++++++++
 tb/tb_addsub_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared constants and owner tag for addsub_arbiter.
// Optional build macro: ADDSUB_ARBITER_FIXED_PRIO_EN (fixed priority arbitration).
package addsub_arbiter_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_LATENCY = 2;
    localparam int MAX_N       = 8;
    // Tag index is sized for the largest supported N so one struct fits all builds
    localparam int TAG_IW      = $clog2(MAX_N);

    typedef struct packed {
        logic              valid;
        logic [TAG_IW-1:0] idx;
    } tag_t;

endpackage

// File: rtl/addsub_arbiter_rr_arbiter.sv
// Grant selection for addsub_arbiter: round-robin from last grant, or fixed
// priority (lowest index) when ADDSUB_ARBITER_FIXED_PRIO_EN is defined.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
`ifndef ADDSUB_ARBITER_FIXED_PRIO_EN
    input  logic [IW-1:0] i_last,
`endif
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

`ifdef ADDSUB_ARBITER_FIXED_PRIO_EN
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        // Descending scan so the lowest asserted index is written last
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_gnt = N'(1) << i;
                o_idx = IW'(i);
            end
        end
    end
`else
    always_comb begin : p_sel
        logic w_found;
        int   w_j;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 1; k <= N; k++) begin
            w_j = (int'(i_last) + k) % N;
            if (!w_found && i_req[w_j]) begin
                w_found = 1'b1;
                o_gnt   = N'(1) << w_j;
                o_idx   = IW'(w_j);
            end
        end
    end
`endif

endmodule

// File: rtl/addsub_arbiter.sv
// Schedules N requesters onto one external add/sub unit and tags results.
// Optional build macro: ADDSUB_ARBITER_FIXED_PRIO_EN (fixed priority arbitration).
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int N       = DEF_N,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N-1:0]              i_req,
    input  logic [N-1:0][WIDTH-1:0]   i_a,
    input  logic [N-1:0][WIDTH-1:0]   i_b,
    input  logic [N-1:0]              i_add,
    output logic [N-1:0]              o_gnt,
    output logic [WIDTH-1:0]          o_op_a,
    output logic [WIDTH-1:0]          o_op_b,
    output logic                      o_op_add,
    input  logic [WIDTH-1:0]          i_op_s,
    output logic [WIDTH-1:0]          o_res,
    output logic [N-1:0]              o_res_valid,
    output logic                      o_idle
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  w_arb_gnt;
    logic [N-1:0]  w_gnt;
    logic [IW-1:0] w_idx;
    logic          w_issue;
    logic          w_busy;
    tag_t          r_tag [LATENCY+1];

`ifndef ADDSUB_ARBITER_FIXED_PRIO_EN
    logic [IW-1:0] r_last;
`endif

    rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .i_req  (i_req),
`ifndef ADDSUB_ARBITER_FIXED_PRIO_EN
        .i_last (r_last),
`endif
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_idx)
    );

    assign w_gnt   = i_rst ? '0 : w_arb_gnt;
    assign o_gnt   = w_gnt;
    assign w_issue = |w_gnt;

    always_comb begin
        w_busy = 1'b0;
        for (int s = 0; s <= LATENCY; s++) begin
            w_busy = w_busy | r_tag[s].valid;
        end
    end

    assign o_idle = !w_busy && !w_issue;

`ifndef ADDSUB_ARBITER_FIXED_PRIO_EN
    // Reset to N-1 so the first search starts at requester 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= IW'(N - 1);
        end else if (w_issue) begin
            r_last <= w_idx;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_op_a   <= '0;
            o_op_b   <= '0;
            o_op_add <= 1'b1;
        end else if (w_issue) begin
            o_op_a   <= i_a[w_idx];
            o_op_b   <= i_b[w_idx];
            o_op_add <= i_add[w_idx];
        end
    end

    // Tag stage 0 is valid alongside the operands; the tail lines up with i_op_s
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s <= LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_issue, idx: TAG_IW'(w_idx)};
            for (int s = 1; s <= LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_res       <= '0;
            o_res_valid <= '0;
        end else begin
            o_res_valid <= r_tag[LATENCY].valid
                         ? (N'(1) << r_tag[LATENCY].idx) : '0;
            if (r_tag[LATENCY].valid) begin
                o_res <= i_op_s;
            end
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter with a cycle-indexed scoreboard.
// Honours ADDSUB_ARBITER_FIXED_PRIO_EN to match the build under test.
module tb_addsub_arbiter;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int HS  = 1024;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req;
    logic [N-1:0][W-1:0] a;
    logic [N-1:0][W-1:0] b;
    logic [N-1:0]        add;
    logic [N-1:0]        o_gnt;
    logic [W-1:0]        o_op_a;
    logic [W-1:0]        o_op_b;
    logic                o_op_add;
    logic [W-1:0]        op_s;
    logic [W-1:0]        o_res;
    logic [N-1:0]        o_res_valid;
    logic                o_idle;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;
    int m_ptr;
    logic [N-1:0] exp_rv  [HS];
    logic [W-1:0] exp_res [HS];
    bit           issued  [HS];

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(W), .N(N), .LATENCY(LAT)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_a         (a),
        .i_b         (b),
        .i_add       (add),
        .o_gnt       (o_gnt),
        .o_op_a      (o_op_a),
        .o_op_b      (o_op_b),
        .o_op_add    (o_op_add),
        .i_op_s      (op_s),
        .o_res       (o_res),
        .o_res_valid (o_res_valid),
        .o_idle      (o_idle)
    );

    // External shared unit: LAT-deep registered add/sub, never reset
    logic [W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= o_op_add ? o_op_a + o_op_b : o_op_a - o_op_b;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign op_s = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r,
                                                input int ptr);
        logic [N-1:0] g;
        int j;
        g = '0;
`ifdef ADDSUB_ARBITER_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) if (r[i]) g = N'(1) << i;
`else
        for (int k = N; k >= 1; k--) begin
            j = (ptr + k) % N;
            if (r[j]) g = N'(1) << j;
        end
`endif
        return g;
    endfunction

    task automatic clear_model();
        m_ptr = N - 1;
        cyc   = 0;
        for (int i = 0; i < HS; i++) begin
            exp_rv[i]  = '0;
            exp_res[i] = '0;
            issued[i]  = 1'b0;
        end
    endtask

    task automatic rnd_ops();
        for (int i = 0; i < N; i++) begin
            a[i]   = W'($urandom);
            b[i]   = W'($urandom);
            add[i] = 1'($urandom);
        end
    endtask

    // One cycle: check at negedge against the scoreboard, then advance
    task automatic tick();
        logic [N-1:0] g;
        logic [W-1:0] v;
        bit idle_e;
        int j;
        @(negedge clk);
        g = model_gnt(req, m_ptr);
        chk("gnt", o_gnt, g);
        chk("res_valid", o_res_valid, exp_rv[cyc]);
        if (exp_rv[cyc] != '0) chk("res", o_res, exp_res[cyc]);
        idle_e = (g == '0);
        for (int k = 1; k <= LAT + 1; k++)
            if (cyc - k >= 0 && issued[cyc-k]) idle_e = 1'b0;
        chk("idle", o_idle, idle_e);
        if (g != '0) begin
            j = 0;
            for (int i = 0; i < N; i++) if (g[i]) j = i;
            v = add[j] ? a[j] + b[j] : a[j] - b[j];
            issued[cyc]          = 1'b1;
            exp_rv[cyc+LAT+2]  = g;
            exp_res[cyc+LAT+2] = v;
            m_ptr = j;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        chk("rst_gnt", o_gnt, '0);
        chk("rst_rv", o_res_valid, '0);
        chk("rst_res", o_res, '0);
        chk("rst_op_a", o_op_a, '0);
        chk("rst_op_b", o_op_b, '0);
        chk("rst_op_add", o_op_add, 1);
        chk("rst_idle", o_idle, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        int gap;
        rst = 1'b1;
        req = '1;
        a   = '0;
        b   = '0;
        add = '0;
        #1;
        do_reset();
        req = '0;

        // Single add request from requester 0
        req = 4'b0001; a[0] = 16'd5; b[0] = 16'd3; add[0] = 1'b1;
        #1;
        chk("single_gnt", o_gnt, 4'b0001);
        tick();
        req = '0;
        chk("op_a", o_op_a, 16'd5);
        chk("op_b", o_op_b, 16'd3);
        chk("op_add", o_op_add, 1);
        tick();
        chk("op_hold", o_op_a, 16'd5);
        tick();
        tick();
        chk("single_res", o_res, 16'd8);
        chk("single_rv", o_res_valid, 4'b0001);
        tick();
        chk("single_idle", o_idle, 1);

        // Subtract wrap-around
        req = 4'b0001; a[0] = 16'h0000; b[0] = 16'h0001; add[0] = 1'b0;
        tick();
        req = '0;
        repeat (4) tick();
        chk("sub_wrap", o_res, 16'hFFFF);
        tick();

        // All requesting for 8 cycles after reset
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            rnd_ops();
            #1;
`ifdef ADDSUB_ARBITER_FIXED_PRIO_EN
            chk("all_seq", o_gnt, 4'b0001);
`else
            chk("rr_seq", o_gnt, N'(1) << (i % N));
`endif
            tick();
        end
        req = '0;
        repeat (6) tick();

        // Reset pulse while an operation is in flight
        do_reset();
        req = 4'b0010;
        rnd_ops();
        tick();
        req = '0;
        tick();
        do_reset();
        chk("post_rst_idle", o_idle, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("flush_rv", o_res_valid, '0);
        end

        // Requester 0 held, others random: bounded wait
        do_reset();
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            req = {3'($urandom), 1'b1};
            rnd_ops();
            #1;
            if (o_gnt[0]) gap = 0;
            else gap++;
            chk("starve", (gap <= N - 1) ? 1 : 0, 1);
            tick();
        end
        req = '0;
        repeat (6) tick();

`ifdef ADDSUB_ARBITER_FIXED_PRIO_EN
        do_reset();
        req = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            rnd_ops();
            #1;
            chk("fixed_prio", o_gnt, 4'b0010);
            tick();
        end
        req = '0;
        repeat (6) tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
